// File: rtl/apb_pkg.sv
// Shared APB width defaults and the master sequencing state type.
package apb_pkg;

   localparam int unsigned APB_DEF_ADDR_WIDTH = 32;
   localparam int unsigned APB_DEF_DATA_WIDTH = 32;
   localparam int unsigned APB_DEF_STRB_WIDTH = APB_DEF_DATA_WIDTH / 8;
   localparam int unsigned APB_DEF_PROT_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after rr_ptr wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters,
// with SETUP/ACCESS sequencing and a bounded PREADYM wait.
module apb_master_arbiter
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned APB_ADDR_WIDTH = APB_DEF_ADDR_WIDTH,
   parameter int unsigned APB_DATA_WIDTH = APB_DEF_DATA_WIDTH,
   parameter int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
   parameter int unsigned APB_PROT_WIDTH = APB_DEF_PROT_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                PCLK,
   input  logic                                PRESETn,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]                  req_write,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*APB_STRB_WIDTH-1:0]   req_strb,
   input  logic [NUM_REQ*APB_PROT_WIDTH-1:0]   req_prot,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
   output logic                                rsp_err,
   output logic                                PSELM,
   output logic                                PENABLEM,
   output logic                                PWRITEM,
   output logic [APB_ADDR_WIDTH-1:0]           PADDRM,
   output logic [APB_DATA_WIDTH-1:0]           PWDATAM,
   output logic [APB_STRB_WIDTH-1:0]           PSTRBM,
   output logic [APB_PROT_WIDTH-1:0]           PPROTM,
   input  logic [APB_DATA_WIDTH-1:0]           PRDATAM,
   input  logic                                PREADYM,
   input  logic                                PSLVERRM
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   apb_state_e                state_q, state_d;
   logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]          owner_q, owner_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [APB_STRB_WIDTH-1:0] pstrb_q, pstrb_d;
   logic [APB_PROT_WIDTH-1:0] pprot_q, pprot_d;
   logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;

   // The response cycle is spent in IDLE without arbitrating, giving the
   // 4-cycle minimum issue interval.
   assign arb_req = req_valid & {NUM_REQ{(state_q == IDLE) && (rsp_valid_q == '0)}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req       (arb_req),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grant is combinational, so it is masked while reset is held.
   assign req_ready = grant & {NUM_REQ{PRESETn}};

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      pprot_d     = pprot_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            if (grant != '0) begin
               paddr_d  = req_addr[grant_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
               pwrite_d = req_write[grant_idx];
               pwdata_d = req_wdata[grant_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
               pstrb_d  = req_strb[grant_idx*APB_STRB_WIDTH +: APB_STRB_WIDTH];
               pprot_d  = req_prot[grant_idx*APB_PROT_WIDTH +: APB_PROT_WIDTH];
               owner_d  = grant_idx;
               rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
               cnt_d    = '0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADYM) begin
               rsp_rdata_d = pwrite_q ? '0 : PRDATAM;
               rsp_err_d   = PSLVERRM;
               rsp_valid_d = NUM_REQ'(1) << owner_q;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = NUM_REQ'(1) << owner_q;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         pprot_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         pprot_q     <= pprot_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign PSELM     = psel_q;
   assign PENABLEM  = penable_q;
   assign PWRITEM   = pwrite_q;
   assign PADDRM    = paddr_q;
   assign PWDATAM   = pwdata_q;
   assign PSTRBM    = pstrb_q;
   assign PPROTM    = pprot_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: stimulus process drives requesters, a negedge monitor plays the
// APB slave, predicts grants by round-robin arithmetic and checks responses.
module tb_apb_master_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned PW = 3;
   localparam int unsigned TO = 4;

   logic              PCLK = 1'b0;
   logic              PRESETn;
   logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N*SW-1:0]   req_strb;
   logic [N*PW-1:0]   req_prot;
   logic [DW-1:0]     rsp_rdata, PWDATAM, PRDATAM;
   logic              rsp_err, PSELM, PENABLEM, PWRITEM, PREADYM, PSLVERRM;
   logic [AW-1:0]     PADDRM;
   logic [SW-1:0]     PSTRBM;
   logic [PW-1:0]     PPROTM;

   apb_master_arbiter #(
      .NUM_REQ        (N),
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .APB_STRB_WIDTH (SW),
      .APB_PROT_WIDTH (PW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .req_prot  (req_prot),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSELM     (PSELM),
      .PENABLEM  (PENABLEM),
      .PWRITEM   (PWRITEM),
      .PADDRM    (PADDRM),
      .PWDATAM   (PWDATAM),
      .PSTRBM    (PSTRBM),
      .PPROTM    (PPROTM),
      .PRDATAM   (PRDATAM),
      .PREADYM   (PREADYM),
      .PSLVERRM  (PSLVERRM)
   );

   always #5 PCLK = ~PCLK;

   int unsigned cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   typedef struct {
      int unsigned r;
      logic [AW-1:0] addr;
      logic wr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [PW-1:0] prot;
      int unsigned gcyc;
   } cmd_t;

   typedef struct {
      int unsigned r;
      logic [DW-1:0] rdata;
      logic err;
      int unsigned cyc;
   } rsp_t;

   // Written by the monitor only
   cmd_t        cmd_q[$];
   rsp_t        rsp_q[$];
   cmd_t        cur, last;
   bit          have_last = 0;
   int          n_tests = 0, n_fail = 0;
   int unsigned grant_cnt[N];
   int          n_rsp = 0, in_flight = 0, stall_seen = 0;
   int unsigned rr = 0;
   int          waits, acc_cnt;
   logic [DW-1:0] s_data;
   logic        s_err;
   bit          final_done = 0;

   // Written by the stimulus process only
   int          force_waits = -1;
   logic [DW-1:0] force_data = '0;
   logic        force_err = 1'b0;
   int          stall_events = 0, stall_target = 0;
   bit          final_req = 0, rand_gap = 0;
   int unsigned seen[N];
   int          left[N], gap[N];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor / APB slave / scoreboard
   initial begin
      PREADYM  = 1'b0;
      PRDATAM  = '0;
      PSLVERRM = 1'b0;
      for (int i = 0; i < N; i++) grant_cnt[i] = 0;
      forever begin
         @(negedge PCLK);
         if (stall_events != stall_seen) begin
            stall_seen = stall_events;
            chk("wait_rsp_count", 64'(n_rsp), 64'(stall_target));
         end
         if (final_req && !final_done) begin
            final_done = 1;
            chk("drain_rsp_q", 64'(rsp_q.size()), 0);
            chk("drain_cmd_q", 64'(cmd_q.size()), 0);
         end
         if (!PRESETn) begin
            chk("rst_ctrl", {PSELM, PENABLEM, PWRITEM, PSTRBM, PPROTM, rsp_valid, rsp_err,
                             req_ready}, 0);
            chk("rst_paddr", PADDRM, 0);
            chk("rst_pwdata", PWDATAM, 0);
            chk("rst_rdata", rsp_rdata, 0);
            cmd_q.delete();
            rsp_q.delete();
            rr        = 0;
            in_flight = 0;
            have_last = 0;
            PREADYM   = 1'b0;
         end else begin
            // Grant prediction from the driven request vector
            if (req_ready != '0) begin
               int unsigned e;
               bit found;
               cmd_t c;
               found = 0;
               e = 0;
               for (int k = 0; k < N; k++) begin
                  int unsigned i;
                  i = (rr + k) % N;
                  if (!found && req_valid[i]) begin
                     e = i;
                     found = 1;
                  end
               end
               chk("grant_onehot", 64'($onehot(req_ready)), 1);
               chk("grant_while_busy", 64'(in_flight), 0);
               for (int i = 0; i < N; i++) if (req_ready[i]) grant_cnt[i]++;
               if (!found) begin
                  chk("grant_without_valid", 64'(req_ready), 0);
               end else begin
                  chk("grant_winner", 64'(req_ready), 64'(1) << e);
                  c.r     = e;
                  c.addr  = req_addr[e*AW +: AW];
                  c.wr    = req_write[e];
                  c.wdata = req_wdata[e*DW +: DW];
                  c.strb  = req_strb[e*SW +: SW];
                  c.prot  = req_prot[e*PW +: PW];
                  c.gcyc  = cyc;
                  cmd_q.push_back(c);
                  rr = (e + 1) % N;
                  in_flight++;
               end
            end
            // APB slave
            if (PSELM && !PENABLEM) begin
               PREADYM = 1'b0;
               if (cmd_q.size() == 0) begin
                  chk("setup_unexpected", 64'(PSELM), 0);
               end else begin
                  rsp_t e;
                  cur = cmd_q.pop_front();
                  last = cur;
                  have_last = 1;
                  chk("setup_latency", 64'(cyc), 64'(cur.gcyc + 1));
                  chk("setup_addr", PADDRM, cur.addr);
                  chk("setup_wdata", PWDATAM, cur.wdata);
                  chk("setup_ctrl", {PWRITEM, PSTRBM, PPROTM}, {cur.wr, cur.strb, cur.prot});
                  waits  = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 5));
                  s_data = (force_waits >= 0) ? force_data : DW'($urandom);
                  s_err  = (force_waits >= 0) ? force_err : ($urandom_range(0, 3) == 0);
                  acc_cnt = 0;
                  e.r = cur.r;
                  if (waits >= int'(TO)) begin
                     e.rdata = '0;
                     e.err   = 1'b1;
                     e.cyc   = cur.gcyc + 2 + TO;
                  end else begin
                     e.rdata = cur.wr ? '0 : s_data;
                     e.err   = s_err;
                     e.cyc   = cur.gcyc + 3 + waits;
                  end
                  rsp_q.push_back(e);
               end
            end else if (PSELM && PENABLEM) begin
               chk("access_addr_stable", PADDRM, cur.addr);
               chk("access_wdata_stable", PWDATAM, cur.wdata);
               chk("access_ctrl_stable", {PWRITEM, PSTRBM, PPROTM},
                   {cur.wr, cur.strb, cur.prot});
               if (acc_cnt == waits) begin
                  PREADYM  = 1'b1;
                  PRDATAM  = s_data;
                  PSLVERRM = s_err;
               end else begin
                  PREADYM  = 1'b0;
                  PRDATAM  = DW'($urandom);
                  PSLVERRM = 1'($urandom);
               end
               acc_cnt++;
            end else begin
               PREADYM = 1'b0;
               chk("penable_without_psel", 64'(PENABLEM), 0);
               if (have_last) chk("idle_addr_hold", PADDRM, last.addr);
            end
            // Response scoreboard
            if (rsp_valid != '0) begin
               if (rsp_q.size() == 0) begin
                  chk("rsp_unexpected", 64'(rsp_valid), 0);
               end else begin
                  rsp_t e;
                  e = rsp_q.pop_front();
                  chk("rsp_target", 64'(rsp_valid), 64'(1) << e.r);
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_err", 64'(rsp_err), 64'(e.err));
                  chk("rsp_latency", 64'(cyc), 64'(e.cyc));
                  in_flight--;
                  n_rsp++;
               end
            end
         end
      end
   end

   task automatic load_random(input int unsigned r);
      req_addr[r*AW +: AW]  = AW'($urandom);
      req_write[r]          = 1'($urandom);
      req_wdata[r*DW +: DW] = DW'($urandom);
      req_strb[r*SW +: SW]  = SW'($urandom);
      req_prot[r*PW +: PW]  = PW'($urandom);
      req_valid[r]          = 1'b1;
   endtask

   task automatic present(input int unsigned r, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic [PW-1:0] p);
      req_addr[r*AW +: AW]  = a;
      req_write[r]          = w;
      req_wdata[r*DW +: DW] = d;
      req_strb[r*SW +: SW]  = s;
      req_prot[r*PW +: PW]  = p;
      req_valid[r]          = 1'b1;
   endtask

   // One cycle of requester behaviour: drop or replace a command once granted
   task automatic step();
      @(posedge PCLK);
      #1;
      for (int r = 0; r < N; r++) begin
         if (grant_cnt[r] != seen[r]) begin
            seen[r] = grant_cnt[r];
            req_valid[r] = 1'b0;
            gap[r] = rand_gap ? int'($urandom_range(0, 3)) : 0;
         end
         if (!req_valid[r] && left[r] > 0) begin
            if (gap[r] > 0) begin
               gap[r]--;
            end else begin
               load_random(r);
               left[r]--;
            end
         end
      end
   endtask

   task automatic wait_rsp(input int target, input int limit);
      int b;
      b = 0;
      while (n_rsp < target && b < limit) begin
         step();
         b++;
      end
      if (n_rsp < target) begin
         stall_target = target;
         stall_events++;
         step();
      end
   endtask

   initial begin
      int base, b;
      PRESETn   = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      for (int r = 0; r < N; r++) begin
         seen[r] = 0;
         left[r] = 0;
         gap[r]  = 0;
      end
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      step();

      // Zero-wait write from requester 0
      force_waits = 0;
      present(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000);
      wait_rsp(1, 50);
      // Read with three wait states
      force_waits = 3;
      force_data  = 32'h12345678;
      force_err   = 1'b0;
      present(1, 32'h20, 1'b0, 32'h0BAD0BAD, 4'h0, 3'b010);
      wait_rsp(2, 50);
      // Slave error on a read
      force_waits = 0;
      force_data  = 32'hCAFE0001;
      force_err   = 1'b1;
      present(1, 32'h24, 1'b0, 32'h0, 4'h0, 3'b001);
      wait_rsp(3, 50);
      // Timeout, then the next request must still be served
      force_waits = 9;
      force_err   = 1'b0;
      present(0, 32'h30, 1'b0, 32'h0, 4'h0, 3'b000);
      wait_rsp(4, 50);
      force_waits = 0;
      present(1, 32'h34, 1'b1, 32'h55AA55AA, 4'h3, 3'b100);
      wait_rsp(5, 50);

      // Reset in the middle of ACCESS; after release requester 0 wins first
      force_waits = 9;
      present(0, 32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
      b = 0;
      while (!PENABLEM && b < 20) begin
         step();
         b++;
      end
      PRESETn = 1'b0;
      present(0, 32'h44, 1'b1, 32'h01020304, 4'hF, 3'b011);
      present(1, 32'h48, 1'b0, 32'h0, 4'h0, 3'b000);
      step();
      step();
      force_waits = 0;
      PRESETn = 1'b1;
      wait_rsp(7, 50);

      // Both requesters continuously valid
      left[0] = 4;
      left[1] = 4;
      base = n_rsp;
      wait_rsp(base + 8, 200);

      // Randomised traffic on all requesters, including timeouts
      force_waits = -1;
      rand_gap    = 1;
      for (int r = 0; r < N; r++) left[r] = 20;
      base = n_rsp;
      wait_rsp(base + 3 * 20, 3000);

      repeat (3) step();
      final_req = 1;
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port (PSELM/PENABLEM/...) between NUM_REQ on-chip requesters using round-robin arbitration.
- Sequences each granted command through the APB SETUP/ACCESS phases and returns read data and error to the winning requester.
- Bounds PREADYM wait states with a timeout counter.
- Sits on the PCLKM side, upstream of the async APB bridge master port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- APB_STRB_WIDTH, APB_DATA_WIDTH/8, byte-strobe width.
- APB_PROT_WIDTH, 3, PPROT width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- req_addr  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester i at slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*APB_STRB_WIDTH  packed strobes.
- req_prot  in  NUM_REQ*APB_PROT_WIDTH  packed protection.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  APB_DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error, valid with rsp_valid.
- PSELM, PENABLEM, PWRITEM  out  1  APB control.
- PADDRM  out  APB_ADDR_WIDTH  APB address.
- PWDATAM  out  APB_DATA_WIDTH  APB write data.
- PSTRBM  out  APB_STRB_WIDTH  APB strobes.
- PPROTM  out  APB_PROT_WIDTH  APB protection.
- PRDATAM  in  APB_DATA_WIDTH  APB read data.
- PREADYM, PSLVERRM  in  1  APB ready and error.

Behaviour:
- Single clock PCLK; reset asynchronous active-low on PRESETn; all state is flopped.
- Reset values: FSM=IDLE, rr_ptr=0, all outputs 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid, pick the winner g by round-robin starting at rr_ptr.
  - Pulse req_ready[g] combinationally for that cycle.
  - Latch addr/write/wdata/strb/prot of g into the PADDRM..PPROTM registers; set rr_ptr=(g+1) mod NUM_REQ; go to SETUP.
  - With no req_valid, stay in IDLE; rr_ptr is unchanged.
- SETUP: PSELM=1, PENABLEM=0; go to ACCESS unconditionally.
- ACCESS:
  - PSELM=1, PENABLEM=1; timeout counter increments each cycle PREADYM=0.
  - On PREADYM=1: register rsp_rdata = PWRITEM ? 0 : PRDATAM, rsp_err = PSLVERRM, pulse rsp_valid[g] for exactly one cycle (the cycle after PREADYM was sampled); drop PSELM/PENABLEM; go to IDLE.
  - Timeout: TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES with PREADYM still 0 -> rsp_err=1, rsp_rdata=0, rsp_valid[g] pulse; drop PSELM/PENABLEM; go to IDLE.
- Address/control stability: PADDRM, PWRITEM, PWDATAM, PSTRBM, PPROTM hold constant from SETUP through the completing ACCESS cycle and keep their value in IDLE (no toggling).
- Latency: req_ready -> PSELM is 1 cycle. With zero wait states, req_ready -> rsp_valid is 3 cycles. Minimum issue interval is 4 cycles per transfer.
- Requester contract: a requester must hold req_valid and its fields stable until req_ready. After req_ready it may deassert or present its next command, and it is eligible again only after the other requesters' turns.
- The timeout counter is sized clog2(TIMEOUT_CYCLES+1) and is cleared on entry to SETUP.
- Reset mid-transfer immediately returns to IDLE with all outputs 0. No rsp_valid is issued for the aborted command.

Decomposition:
- Package apb_pkg: APB width constants and an apb_state_e enum (IDLE, SETUP, ACCESS).
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot grant from req vector and rr_ptr.

Test Plan:
- Single write, requester 0: addr=0x10, wdata=0xDEADBEEF, strb=0xF; PREADYM=1 in the first ACCESS cycle -> PSELM high 2 cycles, PENABLEM 1 cycle; rsp_valid[0] pulse with rsp_err=0, 3 cycles after req_ready[0].
- Read with 3 wait states, PRDATAM=0x12345678 -> PENABLEM high 4 cycles, address stable throughout; rsp_rdata=0x12345678, rsp_err=0.
- Both requesters assert continuously from reset -> grant order 0,1,0,1; req_ready is never two-hot.
- PSLVERRM=1 with PREADYM on a read -> rsp_err=1, rsp_valid to the correct requester.
- TIMEOUT_CYCLES=4, PREADYM held 0 -> rsp_err=1 and rsp_rdata=0 after 4 ACCESS cycles; FSM returns to IDLE and the next request is served.
- PRESETn asserted during ACCESS -> all outputs 0 asynchronously; no rsp_valid; after release requester 0 wins first.
